// File: rtl/csl_pkg.sv
// Shared defaults and configuration helpers for the pipelined carry-select adder.
package csl_pkg;
  localparam int CSL_WIDTH = 32;
  localparam int CSL_BLK   = 8;

  function automatic int csl_nstg(input int width, input int blk);
    return width / blk;
  endfunction

  // A legal configuration has a whole number of segments and at least one of them.
  function automatic bit csl_cfg_ok(input int width, input int blk);
    return (blk > 0) && (width >= blk) && ((width % blk) == 0);
  endfunction
endpackage

// File: rtl/csl_block.sv
// One BLK-bit carry-select segment: two ripple chains (carry-in 0 and 1) and a late mux.
// Purely combinational; c_msb is the carry into bit BLK-1, which the top uses for signed overflow.
module csl_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb
);
  logic [BLK:0]   c0;
  logic [BLK:0]   c1;
  logic [BLK-1:0] s0;
  logic [BLK-1:0] s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    s0    = '0;
    s1    = '0;
    for (int i = 0; i < BLK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign s     = cin ? s1 : s0;
  assign cout  = cin ? c1[BLK] : c0[BLK];
  assign c_msb = cin ? c1[BLK-1] : c0[BLK-1];
endmodule

// File: rtl/csl_pipe_adder.sv
// Pipelined carry-select add/sub, one BLK-bit segment per stage; latency WIDTH/BLK cycles, 1 beat/cycle.
// The whole pipe stalls while the output is held (in_ready = !out_valid || out_ready); bubbles are kept.
module csl_pipe_adder
  import csl_pkg::*;
#(
  parameter int WIDTH = CSL_WIDTH,
  parameter int BLK   = CSL_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSTG = csl_nstg(WIDTH, BLK);

  if (!csl_cfg_ok(WIDTH, BLK)) begin : g_bad_cfg
    $error("csl_pipe_adder: WIDTH must be a non-zero multiple of BLK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_in0;
  logic [NSTG-1:0]  src_vld;
  logic [NSTG-1:0]  ld;
  logic [NSTG-1:0]  vld_q, vld_d;
  logic [NSTG-1:0]  cy_q, cy_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] a_d [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] b_d [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic [WIDTH-1:0] s_d [NSTG];
  logic [BLK-1:0]   seg_a [NSTG];
  logic [BLK-1:0]   seg_b [NSTG];
  logic [BLK-1:0]   seg_s [NSTG];
  logic             seg_cm [NSTG];
  logic [NSTG-1:0]  seg_ci;
  logic [NSTG-1:0]  seg_co;

  assign adv      = !vld_q[NSTG-1] || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c_in0    = sub | cin;
  // Stage k is fed by stage k-1; stage 0 by the input port.
  assign src_vld  = NSTG'({vld_q, in_valid});
  assign ld       = src_vld & {NSTG{adv}};

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    if (k == 0) begin : g_first
      assign seg_a[k]  = a[BLK-1:0];
      assign seg_b[k]  = b_eff[BLK-1:0];
      assign seg_ci[k] = c_in0;
    end else begin : g_next
      assign seg_a[k]  = a_q[k-1][k*BLK +: BLK];
      assign seg_b[k]  = b_q[k-1][k*BLK +: BLK];
      assign seg_ci[k] = cy_q[k-1];
    end

    csl_block #(.BLK(BLK)) u_blk (
      .a     (seg_a[k]),
      .b     (seg_b[k]),
      .cin   (seg_ci[k]),
      .s     (seg_s[k]),
      .cout  (seg_co[k]),
      .c_msb (seg_cm[k])
    );
  end

  // Data registers only load when a valid beat lands, so outputs stay put across bubbles.
  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    ovf_d = ovf_q;
    for (int k = 0; k < NSTG; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
    if (adv) begin
      vld_d = src_vld;
    end
    if (ld[0]) begin
      a_d[0]            = a;
      b_d[0]            = b_eff;
      s_d[0]            = '0;
      s_d[0][BLK-1:0]   = seg_s[0];
      cy_d[0]           = seg_co[0];
    end
    for (int k = 1; k < NSTG; k++) begin
      if (ld[k]) begin
        a_d[k]                = a_q[k-1];
        b_d[k]                = b_q[k-1];
        s_d[k]                = s_q[k-1];
        s_d[k][k*BLK +: BLK]  = seg_s[k];
        cy_d[k]               = seg_co[k];
      end
    end
    if (ld[NSTG-1]) begin
      ovf_d = seg_cm[NSTG-1] ^ seg_co[NSTG-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign sum       = s_q[NSTG-1];
  assign cout      = cy_q[NSTG-1];
  assign ovf       = ovf_q;
endmodule
